// File: rtl/rcpu_core.sv
// rcpu_core: multi-cycle stack/register CPU with ready/valid memory and I/O.
// Define RCPU_MULDIV_EN to enable ATH multiply (2) and divide (3).
module rcpu_core #(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 15,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_read_address,
  input  logic              mem_read_valid,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              io_read_enable,
  output logic              io_write_enable,
  output logic [DATA_W-1:0] io_address,
  output logic [DATA_W-1:0] io_write_data,
  input  logic              io_ready,
  input  logic [DATA_W-1:0] io_read_data,
  output logic              halted,
  output logic [1:0]        fault
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [DATA_W-1:0] LEET = DATA_W'(1337);

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_LDV = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_LDM = 4'h3;
  localparam logic [3:0] OP_LDR = 4'h4;
  localparam logic [3:0] OP_LDP = 4'h5;
  localparam logic [3:0] OP_ATH = 4'h6;
  localparam logic [3:0] OP_CAL = 4'h7;
  localparam logic [3:0] OP_RET = 4'h8;
  localparam logic [3:0] OP_JLT = 4'h9;
  localparam logic [3:0] OP_PSH = 4'hA;
  localparam logic [3:0] OP_POP = 4'hB;
  localparam logic [3:0] OP_SYS = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JRM = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MEM, S_IO, S_WB, S_HALT
  } state_t;

  state_t r_state, w_state;

  logic [DATA_W-1:0] r_pc, r_data;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [4];
  logic [DATA_W-1:0] r_stk [2**SPW];
  logic [SPW-1:0]    r_sp;

  logic              r_rd_en, w_rd_en;
  logic [DATA_W-1:0] r_rd_addr, w_rd_addr;
  logic              r_wr_en, w_wr_en;
  logic [DATA_W-1:0] r_wr_addr, w_wr_addr;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;
  logic              r_io_rd, w_io_rd;
  logic              r_io_wr, w_io_wr;
  logic [DATA_W-1:0] r_io_addr, w_io_addr;
  logic [DATA_W-1:0] r_io_wdata, w_io_wdata;
  logic              r_halted, w_halted;
  logic [1:0]        r_fault, w_fault;

  logic [3:0]        w_op, w_aop;
  logic [1:0]        w_dst, w_src;
  logic [2:0]        w_sh;
  logic              w_m;
  logic [DATA_W-1:0] w_arg, w_a, w_b, w_pc1;
  logic [DATA_W-1:0] w_top, w_nxt, w_alu;
  logic              w_push, w_pop, w_full, w_empty;
  logic              w_rf_we;
  logic [1:0]        w_rf_idx;
  logic [DATA_W-1:0] w_rf_val, w_pc_n, w_push_val;

  assign w_op   = r_ir[3:0];
  assign w_dst  = r_ir[5:4];
  assign w_src  = r_ir[7:6];
  assign w_aop  = r_ir[11:8];
  assign w_m    = r_ir[12];
  assign w_sh   = r_ir[15:13];
  assign w_arg  = DATA_W'(r_ir[15:6]);
  assign w_a    = r_regs[w_dst];
  assign w_b    = r_regs[w_src];
  assign w_pc1  = r_pc + DATA_W'(1);

  assign w_top   = r_stk[r_sp - SPW'(1)];
  assign w_nxt   = (r_sp >= SPW'(2)) ? r_stk[r_sp - SPW'(2)] : '0;
  assign w_full  = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_push  = (w_op == OP_CAL) || (w_op == OP_PSH);
  assign w_pop   = (w_op == OP_RET) || (w_op == OP_POP) ||
                   (w_op == OP_SYS);
  assign w_push_val = (w_op == OP_CAL) ? w_pc1 : w_b;

  always_comb begin
    w_alu = LEET;
    case (w_aop)
      4'h0: w_alu = w_a + w_b;
      4'h1: w_alu = w_a - w_b;
`ifdef RCPU_MULDIV_EN
      4'h2: w_alu = w_a * w_b;
      4'h3: w_alu = (w_b == '0) ? '1 : w_a / w_b;
`endif
      4'h4: w_alu = w_a << w_sh;
      4'h5: w_alu = w_a >> w_sh;
      4'h6: w_alu = w_a & w_b;
      4'h7: w_alu = w_a | w_b;
      4'h8: w_alu = w_a ^ w_b;
      4'h9: w_alu = ~w_b;
      4'hA: w_alu = w_a + DATA_W'(1);
      4'hB: w_alu = w_a - DATA_W'(1);
      default: w_alu = LEET;
    endcase
  end

  always_comb begin
    w_rf_we  = 1'b0;
    w_rf_idx = w_dst;
    w_rf_val = '0;
    w_pc_n   = w_pc1;
    case (w_op)
      OP_MOV: begin w_rf_we = 1'b1; w_rf_val = w_b; end
      OP_LDV: begin w_rf_we = 1'b1; w_rf_val = w_arg; end
      OP_LDA, OP_LDR: begin
        w_rf_we  = 1'b1;
        w_rf_val = r_data;
      end
      OP_ATH: begin
        w_rf_we  = 1'b1;
        w_rf_idx = w_m ? w_src : w_dst;
        w_rf_val = w_alu;
      end
      OP_POP: begin w_rf_we = 1'b1; w_rf_val = w_top; end
      OP_SYS: begin w_rf_we = w_top[1]; w_rf_val = r_data; end
      OP_CAL: w_pc_n = w_a;
      OP_RET: w_pc_n = w_top;
      OP_JLT: w_pc_n = (w_a > r_regs[0]) ? w_b : w_pc1;
      OP_JMP: w_pc_n = w_arg;
      OP_JRM: w_pc_n = w_b;
      default: ;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_rd_en    = r_rd_en;
    w_rd_addr  = r_rd_addr;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_wr_addr;
    w_wr_data  = r_wr_data;
    w_io_rd    = r_io_rd;
    w_io_wr    = r_io_wr;
    w_io_addr  = r_io_addr;
    w_io_wdata = r_io_wdata;
    w_halted   = r_halted;
    w_fault    = r_fault;
    unique case (r_state)
      S_FETCH: begin
        if (!r_rd_en) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_pc;
        end else if (mem_read_valid) begin
          w_rd_en = 1'b0;
          w_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_push && w_full) begin
          w_fault[1] = 1'b1;
          w_halted   = 1'b1;
          w_state    = S_HALT;
        end else if (w_pop && w_empty) begin
          w_fault[0] = 1'b1;
          w_halted   = 1'b1;
          w_state    = S_HALT;
        end else if (w_op == OP_HLT) begin
          w_halted = 1'b1;
          w_state  = S_HALT;
        end else if (w_op == OP_LDA || w_op == OP_LDR) begin
          w_rd_en   = 1'b1;
          w_rd_addr = (w_op == OP_LDA) ? w_arg : w_b;
          w_state   = S_MEM;
        end else if (w_op == OP_SYS && (w_top[0] || w_top[1])) begin
          w_io_wr    = w_top[0];
          w_io_rd    = w_top[1];
          w_io_addr  = {w_top[DATA_W-1:2], 2'b00};
          w_io_wdata = w_nxt;
          w_state    = S_IO;
        end else begin
          w_state = S_WB;
          // store strobe lands in the WB cycle
          if (w_op == OP_LDM || w_op == OP_LDP) begin
            w_wr_en   = 1'b1;
            w_wr_addr = (w_op == OP_LDM) ? w_arg : w_a;
            w_wr_data = (w_op == OP_LDM) ? w_a : w_b;
          end
        end
      end
      S_MEM: begin
        if (mem_read_valid) begin
          w_rd_en = 1'b0;
          w_state = S_WB;
        end
      end
      S_IO: begin
        if (io_ready) begin
          w_io_rd = 1'b0;
          w_io_wr = 1'b0;
          w_state = S_WB;
        end
      end
      S_WB: begin
        w_rd_en   = 1'b1;
        w_rd_addr = w_pc_n;
        w_state   = S_FETCH;
      end
      S_HALT: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= DATA_W'(RESET_PC);
      r_ir       <= '0;
      r_data     <= '0;
      r_sp       <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_io_rd    <= 1'b0;
      r_io_wr    <= 1'b0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
      r_halted   <= 1'b0;
      r_fault    <= 2'b00;
    end else begin
      r_state    <= w_state;
      r_rd_en    <= w_rd_en;
      r_rd_addr  <= w_rd_addr;
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= w_wr_data;
      r_io_rd    <= w_io_rd;
      r_io_wr    <= w_io_wr;
      r_io_addr  <= w_io_addr;
      r_io_wdata <= w_io_wdata;
      r_halted   <= w_halted;
      r_fault    <= w_fault;
      if (r_state == S_FETCH && r_rd_en && mem_read_valid)
        r_ir <= mem_read_data[15:0];
      if (r_state == S_MEM && mem_read_valid)
        r_data <= mem_read_data;
      if (r_state == S_IO && io_ready)
        r_data <= io_read_data;
      if (r_state == S_WB) begin
        r_pc <= w_pc_n;
        if (w_rf_we) r_regs[w_rf_idx] <= w_rf_val;
        if (w_push) r_sp <= r_sp + SPW'(1);
        else if (w_pop) r_sp <= r_sp - SPW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_WB && w_push)
      r_stk[r_sp] <= w_push_val;
  end

  assign mem_read_enable   = r_rd_en;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_enable  = r_wr_en;
  assign mem_write_address = r_wr_addr;
  assign mem_write_data    = r_wr_data;
  assign io_read_enable    = r_io_rd;
  assign io_write_enable   = r_io_wr;
  assign io_address        = r_io_addr;
  assign io_write_data     = r_io_wdata;
  assign halted            = r_halted;
  assign fault             = r_fault;

endmodule

// File: tb/tb_rcpu_core.sv
// tb_rcpu_core: directed programs against rcpu_core with a
// delay-configurable memory and I/O responder.
module tb_rcpu_core;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read_enable, mem_write_enable;
  logic [W-1:0] mem_read_address, mem_write_address, mem_write_data;
  logic         mem_read_valid;
  logic [W-1:0] mem_read_data;
  logic         io_read_enable, io_write_enable, io_ready;
  logic [W-1:0] io_address, io_write_data, io_read_data;
  logic         halted;
  logic [1:0]   fault;

  rcpu_core #(.DATA_W(W), .STACK_DEPTH(15), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .mem_read_enable(mem_read_enable),
    .mem_read_address(mem_read_address),
    .mem_read_valid(mem_read_valid),
    .mem_read_data(mem_read_data),
    .mem_write_enable(mem_write_enable),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .io_read_enable(io_read_enable),
    .io_write_enable(io_write_enable),
    .io_address(io_address),
    .io_write_data(io_write_data),
    .io_ready(io_ready),
    .io_read_data(io_read_data),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:255];
  int rd_delay, io_delay, rcnt, icnt;
  logic [W-1:0] io_rdata;
  assign io_read_data = io_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_valid <= 1'b0;
      mem_read_data  <= '0;
      rcnt           <= 0;
    end else begin
      mem_read_valid <= 1'b0;
      if (mem_read_enable && !mem_read_valid) begin
        if (rcnt >= rd_delay) begin
          mem_read_valid <= 1'b1;
          mem_read_data  <= mem[mem_read_address[7:0]];
          rcnt           <= 0;
        end else rcnt <= rcnt + 1;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      io_ready <= 1'b0;
      icnt     <= 0;
    end else begin
      io_ready <= 1'b0;
      if ((io_read_enable || io_write_enable) && !io_ready) begin
        if (icnt >= io_delay) begin
          io_ready <= 1'b1;
          icnt     <= 0;
        end else icnt <= icnt + 1;
      end
    end
  end

  int cyc, fcnt, wcnt, stab_err, iow_cyc;
  int req_t [0:255];
  logic [W-1:0] fa [0:63];
  logic [W-1:0] wa [0:15];
  logic [W-1:0] wd [0:15];
  logic [W-1:0] last_ra, prev_addr, io_cap_addr, io_cap_wd;
  logic [1:0]   io_cap_we;
  logic         prev_en;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; fcnt <= 0; wcnt <= 0;
      stab_err <= 0; iow_cyc <= 0;
      prev_en <= 1'b0; prev_addr <= '0;
      io_cap_addr <= '0; io_cap_wd <= '0; io_cap_we <= 2'b00;
    end else begin
      cyc       <= cyc + 1;
      prev_en   <= mem_read_enable;
      prev_addr <= mem_read_address;
      if (mem_read_enable && !prev_en) begin
        req_t[mem_read_address[7:0]] <= cyc;
        fa[fcnt[5:0]] <= mem_read_address;
        last_ra <= mem_read_address;
        fcnt <= fcnt + 1;
      end
      if (mem_read_enable && prev_en && mem_read_address != prev_addr)
        stab_err <= stab_err + 1;
      if (mem_write_enable) begin
        wa[wcnt[3:0]] <= mem_write_address;
        wd[wcnt[3:0]] <= mem_write_data;
        wcnt <= wcnt + 1;
      end
      if (io_write_enable) iow_cyc <= iow_cyc + 1;
      if (io_ready && (io_write_enable || io_read_enable)) begin
        io_cap_addr <= io_address;
        io_cap_wd   <= io_write_data;
        io_cap_we   <= {io_write_enable, io_read_enable};
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] i_rr(input logic [3:0] op,
      input logic [1:0] d, input logic [1:0] s);
    return {8'h00, s, d, op};
  endfunction

  function automatic logic [15:0] i_arg(input logic [3:0] op,
      input logic [1:0] d, input logic [9:0] a);
    return {a, d, op};
  endfunction

  function automatic logic [15:0] i_ath(input logic [3:0] aop,
      input logic [1:0] d, input logic [1:0] s, input logic m,
      input logic [2:0] sh);
    return {sh, m, aop, s, d, 4'h6};
  endfunction

  task automatic mem_clear();
    for (int i = 0; i < 256; i++) mem[i] = 16'h000D;
    rd_delay = 0;
    io_delay = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_halted"}, 32'(halted), 1);
    check({tag, "_idle"}, 32'(mem_read_enable), 0);
  endtask

  task automatic ath_case(input string tag, input logic [3:0] aop,
      input logic [9:0] a, input logic [9:0] b, input logic m,
      input logic [2:0] sh, input logic [W-1:0] exp);
    mem_clear();
    mem[0] = i_arg(4'h1, 2'd1, a);
    mem[1] = i_arg(4'h1, 2'd2, b);
    mem[2] = i_ath(aop, 2'd1, 2'd2, m, sh);
    mem[3] = i_arg(4'h3, m ? 2'd2 : 2'd1, 10'h040);
    do_reset();
    run(tag, 300);
    check({tag, "_wcnt"}, wcnt, 1);
    check({tag, "_res"}, 32'(wd[0]), 32'(exp));
  endtask

  logic [W-1:0] mul_exp;

  initial begin
    reset    = 1'b1;
    io_rdata = 16'hA5A5;
    mem_clear();
    #1;
    check("rst_en", {mem_read_enable, mem_write_enable,
          io_read_enable, io_write_enable, halted, fault}, 0);
    check("rst_bus", 32'(|{mem_read_address, mem_write_address,
          mem_write_data, io_address, io_write_data}), 0);

    ath_case("add", 4'h0, 10'd5, 10'd7, 1'b0, 3'd0, 16'd12);
    check("add_addr", 32'(wa[0]), 32'h40);
    check("alu_4cyc", req_t[3] - req_t[2], 4);
    ath_case("sub", 4'h1, 10'd5, 10'd7, 1'b0, 3'd0, 16'hFFFE);
    ath_case("shl", 4'h4, 10'd5, 10'd0, 1'b0, 3'd3, 16'h0028);
    ath_case("shr", 4'h5, 10'h3FF, 10'd0, 1'b0, 3'd2, 16'h00FF);
    ath_case("and", 4'h6, 10'h03C, 10'h00F, 1'b0, 3'd0, 16'h000C);
    ath_case("or", 4'h7, 10'h030, 10'h00F, 1'b0, 3'd0, 16'h003F);
    ath_case("xor", 4'h8, 10'h0FF, 10'h00F, 1'b0, 3'd0, 16'h00F0);
    ath_case("not", 4'h9, 10'h000, 10'h00F, 1'b0, 3'd0, 16'hFFF0);
    ath_case("inc", 4'hA, 10'h3FF, 10'h000, 1'b0, 3'd0, 16'h0400);
    ath_case("dec", 4'hB, 10'h000, 10'h000, 1'b0, 3'd0, 16'hFFFF);
`ifdef RCPU_MULDIV_EN
    mul_exp = 16'd35;
`else
    mul_exp = 16'd1337;
`endif
    ath_case("op2", 4'h2, 10'd5, 10'd7, 1'b0, 3'd0, mul_exp);
    ath_case("op12", 4'hC, 10'd5, 10'd7, 1'b0, 3'd0, 16'd1337);
    ath_case("m1", 4'h1, 10'd9, 10'd4, 1'b1, 3'd0, 16'd5);

    mem_clear();
    rd_delay = 3;
    mem[0] = i_arg(4'h2, 2'd0, 10'h020);
    mem[1] = i_arg(4'h3, 2'd0, 10'h041);
    mem[8'h20] = 16'hBEEF;
    do_reset();
    run("lda", 400);
    check("lda_data", 32'(wd[0]), 32'hBEEF);
    check("lda_addr", 32'(wa[0]), 32'h41);
    check("lda_stable", stab_err, 0);
    check("lda_cyc", req_t[1] - req_t[0], 12);

    mem_clear();
    for (int i = 0; i < 16; i++) mem[i] = i_rr(4'hA, 2'd0, 2'd0);
    do_reset();
    run("ovf", 600);
    check("ovf_fault", 32'(fault), 32'h2);
    check("ovf_pc", 32'(last_ra), 32'd15);

    mem_clear();
    mem[0] = i_rr(4'hB, 2'd1, 2'd0);
    do_reset();
    run("unf", 100);
    check("unf_fault", 32'(fault), 32'h1);
    check("unf_fetch", fcnt, 1);

    mem_clear();
    io_delay = 2;
    mem[0] = i_arg(4'h1, 2'd1, 10'h055);
    mem[1] = i_rr(4'hA, 2'd0, 2'd1);
    mem[2] = i_arg(4'h1, 2'd2, 10'h101);
    mem[3] = i_rr(4'hA, 2'd0, 2'd2);
    mem[4] = i_rr(4'hC, 2'd3, 2'd0);
    do_reset();
    run("sysw", 300);
    check("sysw_addr", 32'(io_cap_addr), 32'h100);
    check("sysw_data", 32'(io_cap_wd), 32'h55);
    check("sysw_strb", 32'(io_cap_we), 32'h2);
    check("sysw_hold", iow_cyc, 4);
    check("sysw_fault", 32'(fault), 0);

    mem_clear();
    mem[0] = i_arg(4'h1, 2'd2, 10'h202);
    mem[1] = i_rr(4'hA, 2'd0, 2'd2);
    mem[2] = i_rr(4'hC, 2'd3, 2'd0);
    mem[3] = i_arg(4'h3, 2'd3, 10'h042);
    do_reset();
    run("sysr", 300);
    check("sysr_addr", 32'(io_cap_addr), 32'h200);
    check("sysr_strb", 32'(io_cap_we), 32'h1);
    check("sysr_data", 32'(wd[0]), 32'hA5A5);

    mem_clear();
    mem[0] = i_arg(4'h1, 2'd1, 10'h010);
    mem[1] = i_rr(4'h7, 2'd1, 2'd0);
    mem[8'h10] = i_rr(4'h8, 2'd0, 2'd0);
    mem[2] = i_arg(4'h3, 2'd1, 10'h043);
    do_reset();
    run("cal", 300);
    check("cal_tgt", 32'(fa[2]), 32'h10);
    check("ret_tgt", 32'(fa[3]), 32'h2);
    check("cal_wr", 32'(wd[0]), 32'h10);
    check("cal_fault", 32'(fault), 0);

    mem_clear();
    mem[0] = i_arg(4'h1, 2'd0, 10'd3);
    mem[1] = i_arg(4'h1, 2'd1, 10'd4);
    mem[2] = i_arg(4'h1, 2'd2, 10'h020);
    mem[3] = i_rr(4'h9, 2'd1, 2'd2);
    mem[8'h20] = i_arg(4'h1, 2'd1, 10'd3);
    mem[8'h21] = i_rr(4'h9, 2'd1, 2'd2);
    do_reset();
    run("jlt", 300);
    check("jlt_taken", 32'(fa[4]), 32'h20);
    check("jlt_not", 32'(fa[6]), 32'h22);
    check("jlt_fcnt", fcnt, 7);

    mem_clear();
    mem[0]  = i_arg(4'h1, 2'd1, 10'h030);
    mem[1]  = i_arg(4'h1, 2'd2, 10'h1AB);
    mem[2]  = i_rr(4'h5, 2'd1, 2'd2);
    mem[3]  = i_rr(4'h0, 2'd3, 2'd2);
    mem[4]  = i_rr(4'hA, 2'd0, 2'd3);
    mem[5]  = i_rr(4'hB, 2'd0, 2'd0);
    mem[6]  = i_arg(4'h3, 2'd0, 10'h044);
    mem[7]  = i_arg(4'h1, 2'd1, 10'h021);
    mem[8]  = i_rr(4'h4, 2'd0, 2'd1);
    mem[9]  = i_arg(4'h3, 2'd0, 10'h045);
    mem[10] = i_arg(4'h1, 2'd3, 10'h028);
    mem[11] = i_rr(4'hF, 2'd0, 2'd3);
    mem[8'h21] = 16'h1234;
    mem[8'h28] = i_arg(4'hE, 2'd0, 10'h02C);
    do_reset();
    run("misc", 500);
    check("ldp_addr", 32'(wa[0]), 32'h30);
    check("ldp_data", 32'(wd[0]), 32'h1AB);
    check("pop_data", 32'(wd[1]), 32'h1AB);
    check("ldr_data", 32'(wd[2]), 32'h1234);
    check("misc_wcnt", wcnt, 3);
    check("jmp_end", 32'(last_ra), 32'h2C);
    check("misc_fault", 32'(fault), 0);

    mem_clear();
    rd_delay = 5;
    mem[0] = i_arg(4'h2, 2'd0, 10'h020);
    do_reset();
    begin
      int n = 0;
      while (!(mem_read_enable && mem_read_address == 16'h20) &&
             n < 200) begin
        @(negedge clk);
        n++;
      end
      check("mid_seen", 32'(n < 200), 1);
    end
    #1 reset = 1'b1;
    #1;
    check("mid_en", {mem_read_enable, mem_write_enable,
          io_read_enable, io_write_enable, halted, fault}, 0);
    check("mid_bus", 32'(|{mem_read_address, mem_write_address,
          mem_write_data, io_address, io_write_data}), 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int n = 0;
      while (!mem_read_enable && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("restart_req", 32'(mem_read_enable), 1);
      check("restart_pc", 32'(mem_read_address), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rcpu_core.md
# rcpu_core

Parametrised successor to the fixed 16-bit RCPU: a multi-cycle, single-issue stack/register CPU with configurable data width and stack depth. It replaces fixed memory wait states with ready/valid handshakes on instruction/data memory and I/O, and adds stack overflow/underflow detection and an explicit halted state. It sits between the board-level memory/IO fabric and the program ROM/RAM.

## Interface
- DATA_W, 16: register, stack, memory-data and address width (≥16); instructions are always the low 16 bits of a fetched word.
- STACK_DEPTH, 15: data-stack entries including top-of-stack (≥2).
- RESET_PC, 0: program counter after reset.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read_enable  out  1  read request; held until mem_read_valid.
- mem_read_address  out  DATA_W  read address; stable while request held.
- mem_read_valid  in  1  read data valid; earliest one cycle after request.
- mem_read_data  in  DATA_W  read data.
- mem_write_enable  out  1  single-cycle write strobe; no backpressure.
- mem_write_address  out  DATA_W  write address.
- mem_write_data  out  DATA_W  write data.
- io_read_enable / io_write_enable  out  1 each  I/O strobes; held until io_ready.
- io_address  out  DATA_W  word-aligned I/O address.
- io_write_data  out  DATA_W  I/O write data.
- io_ready  in  1  I/O transfer complete this cycle.
- io_read_data  in  DATA_W  I/O read data, sampled when io_ready.
- halted  out  1  core stopped (HLT or fault).
- fault  out  2  sticky {overflow, underflow}.

## Operation
- Fields (value bit numbering): opcode [3:0], dst [5:4], src [7:6], arg [15:6] zero-extended, ath_op [11:8], M [12], shamt [15:13]. Four registers R0–R3.
- Opcodes: 0 MOV dst←src; 1 LDV dst←arg; 2 LDA dst←mem[arg]; 3 LDM mem[arg]←dst; 4 LDR dst←mem[src]; 5 LDP mem[dst]←src; 6 ATH; 7 CAL push pc+1, pc←dst; 8 RET pc←pop; 9 JLT pc←src if dst > R0 (unsigned) else pc+1; A PSH push src; B POP dst←pop; C SYS; D HLT; E JMP pc←arg; F JRM pc←src.
- ATH: 0 add, 1 sub, 4 shl shamt, 5 shr shamt (logical), 6 and, 7 or, 8 xor, 9 ~src, A dst+1, B dst−1; 2/3 per Configuration; others write 1337. Result to src if M=1, else dst. All arithmetic modulo 2^DATA_W.
- SYS: pops address word A; io_write_enable=A[0], io_read_enable=A[1], io_address={A[DATA_W-1:2],2'b00}, io_write_data=new top after pop; on read, dst←io_read_data. Both bits clear: pop only, no I/O cycle.
- Stack: depth counter 0..STACK_DEPTH. Push at full → overflow; pop (RET, POP, SYS) at empty → underflow. Faulting instruction commits nothing; fault bit set, core enters HALT.
- States: FETCH (request at pc; on valid latch instruction) → EXEC (decode; LDA/LDR → MEM, SYS with I/O → IO, else WB) → MEM (request; on valid latch data) / IO (hold strobes; on io_ready latch data) → WB (commit register, pc, stack; LDM/LDP strobe mem_write_enable) → FETCH, or HALT on HLT/fault. HALT: halted=1, no bus activity, exits only on reset.

## Timing
- Reset: pc=RESET_PC, registers 0, stack empty, state FETCH; every output 0.
- With one-cycle memory/IO response: ALU/branch/stack ops 4 cycles, LDA/LDR/SYS-with-I/O 6; each extra response cycle adds one.
- Request outputs are registered and never change while waiting.
- Reset mid-transaction drops the request at once; late valid/ready ignored.
- pc wraps modulo 2^DATA_W.

## Configuration
- RCPU_MULDIV_EN defined: ATH 2 = low DATA_W bits of dst×src; ATH 3 = dst/src unsigned, divide-by-zero yields all-ones.
- Undefined: ATH 2/3 write 1337 like other unused ops; no multiplier/divider synthesised.

## Test plan
- LDV R1,5; LDV R2,7; ATH add → R1=12; next fetch 4 cycles after previous fetch with one-cycle memory.
- LDA R0,0x20 with mem[0x20]=0xBEEF, valid delayed 3 cycles → R0=0xBEEF, mem_read_address stable throughout.
- PSH ×STACK_DEPTH then one more PSH → fault=2'b10, halted=1, pc unchanged; POP on empty after reset → fault=2'b01.
- PSH data 0x55, PSH 0x0101 (write, addr 0x100), SYS → io_write_enable held until io_ready, io_address=0x100, io_write_data=0x55.
- CAL to 0x10 then RET → pc returns to CAL+1; JLT with R0=3, dst=4 taken, dst=3 not taken.
- Assert reset while in MEM → all outputs 0 immediately; fetch restarts at RESET_PC.
